apb_arbiter_2to1: RTL and testbench

- Shares one downstream APB completer (typically an apb_delayer-fronted peripheral) between two APB requesters, m0 and m1; e.g. CPU LSU and a DMA engine.
- Each requester transfer is captured on grant and replayed downstream as a registered SETUP/ACCESS sequence.
- The response is returned to the granted requester only. The other requester is stalled.
- A watchdog terminates hung downstream accesses with an error.

---
 rtl/apb_arbiter_2to1.sv | 158 +++++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_2to1.sv
// Two-requester APB arbiter: captures the granted transfer, replays it to one
// downstream completer and routes the response back to the granted requester.
module apb_arbiter_2to1 #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_paddr,
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic [2:0]  m0_pprot,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_pwdata,
  input  logic [3:0]  m0_pstrb,
  output logic        m0_pready,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  input  logic [31:0] m1_paddr,
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic [2:0]  m1_pprot,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_pwdata,
  input  logic [3:0]  m1_pstrb,
  output logic        m1_pready,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 3;
  localparam int unsigned SW  = 4;
  localparam int unsigned WDW = 16;

  localparam bit             TMO_EN    = (TIMEOUT != 0);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] prot;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t         state;
  logic           gnt;
  logic           last;
  logic [WDW-1:0] wdog;
  req_t           out_req;
  req_t           m0_req;
  req_t           m1_req;
  logic           pick;
  logic           done;
  logic           tmo;

  // penable from the requesters plays no part in arbitration
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign m0_req = {m0_paddr, m0_pprot, m0_pwrite, m0_pwdata, m0_pstrb};
  assign m1_req = {m1_paddr, m1_pprot, m1_pwrite, m1_pwdata, m1_pstrb};

  assign out_paddr  = out_req.addr;
  assign out_pprot  = out_req.prot;
  assign out_pwrite = out_req.write;
  assign out_pwdata = out_req.wdata;
  assign out_pstrb  = out_req.strb;

  assign done = (state == ACCESS) && out_pready;
  assign tmo  = (state == ACCESS) && !out_pready && TMO_EN && (wdog == WDOG_LAST);

  // Contention goes to the requester not served last (round robin) or to m0
  always_comb begin
    pick = m1_psel;
    if (m0_psel && m1_psel) begin
      pick = ROUND_ROBIN ? ~last : 1'b0;
    end
  end

  // Response is visible only to the granted requester, only in its completion cycle
  always_comb begin
    m0_pready  = 1'b0;
    m0_prdata  = '0;
    m0_pslverr = 1'b0;
    m1_pready  = 1'b0;
    m1_prdata  = '0;
    m1_pslverr = 1'b0;
    if (done || tmo) begin
      if (gnt) begin
        m1_pready  = 1'b1;
        m1_prdata  = done ? out_prdata : '0;
        m1_pslverr = done ? out_pslverr : 1'b1;
      end else begin
        m0_pready  = 1'b1;
        m0_prdata  = done ? out_prdata : '0;
        m0_pslverr = done ? out_pslverr : 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last        <= 1'b1;
      wdog        <= '0;
      out_req     <= '0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            gnt         <= pick;
            out_req     <= pick ? m1_req : m0_req;
            out_psel    <= 1'b1;
            out_penable <= 1'b0;
            wdog        <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          out_penable <= 1'b1;
          wdog        <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (done || tmo) begin
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            last        <= gnt;
            state       <= IDLE;
          end else if (wdog != '1) begin
            // timeout compare happens before the increment, so this only saturates when disabled
            wdog <= wdog + WDW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Bench for apb_arbiter_2to1: directed scenarios plus randomized two-requester
// traffic checked against a transfer-level reference model.
module tb_apb_arbiter_2to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] rq_addr [2];
  logic [2:0]  rq_prot [2];
  logic        rq_write[2];
  logic [31:0] rq_wdata[2];
  logic [3:0]  rq_strb [2];
  logic        rq_sel  [2];
  logic        rq_en   [2];

  logic        ds_ready;
  logic [31:0] ds_rdata_bus;
  logic        ds_err_bus;

  // dut_a: round robin, TIMEOUT=8; dut_b: fixed priority, no watchdog
  logic        a_psel, a_pen, a_pwrite, b_psel, b_pen, b_pwrite;
  logic [31:0] a_paddr, a_pwdata, b_paddr, b_pwdata;
  logic [2:0]  a_pprot, b_pprot;
  logic [3:0]  a_pstrb, b_pstrb;
  logic        a_rdy[2], a_err[2], b_rdy[2], b_err[2];
  logic [31:0] a_rdata[2], b_rdata[2];

  apb_arbiter_2to1 #(.ROUND_ROBIN(1'b1), .TIMEOUT(8)) dut_a (
    .clock(clk), .reset(reset),
    .m0_paddr(rq_addr[0]), .m0_psel(rq_sel[0]), .m0_penable(rq_en[0]), .m0_pprot(rq_prot[0]),
    .m0_pwrite(rq_write[0]), .m0_pwdata(rq_wdata[0]), .m0_pstrb(rq_strb[0]),
    .m0_pready(a_rdy[0]), .m0_prdata(a_rdata[0]), .m0_pslverr(a_err[0]),
    .m1_paddr(rq_addr[1]), .m1_psel(rq_sel[1]), .m1_penable(rq_en[1]), .m1_pprot(rq_prot[1]),
    .m1_pwrite(rq_write[1]), .m1_pwdata(rq_wdata[1]), .m1_pstrb(rq_strb[1]),
    .m1_pready(a_rdy[1]), .m1_prdata(a_rdata[1]), .m1_pslverr(a_err[1]),
    .out_paddr(a_paddr), .out_psel(a_psel), .out_penable(a_pen), .out_pprot(a_pprot),
    .out_pwrite(a_pwrite), .out_pwdata(a_pwdata), .out_pstrb(a_pstrb),
    .out_pready(ds_ready), .out_prdata(ds_rdata_bus), .out_pslverr(ds_err_bus)
  );

  apb_arbiter_2to1 #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_b (
    .clock(clk), .reset(reset),
    .m0_paddr(rq_addr[0]), .m0_psel(rq_sel[0]), .m0_penable(rq_en[0]), .m0_pprot(rq_prot[0]),
    .m0_pwrite(rq_write[0]), .m0_pwdata(rq_wdata[0]), .m0_pstrb(rq_strb[0]),
    .m0_pready(b_rdy[0]), .m0_prdata(b_rdata[0]), .m0_pslverr(b_err[0]),
    .m1_paddr(rq_addr[1]), .m1_psel(rq_sel[1]), .m1_penable(rq_en[1]), .m1_pprot(rq_prot[1]),
    .m1_pwrite(rq_write[1]), .m1_pwdata(rq_wdata[1]), .m1_pstrb(rq_strb[1]),
    .m1_pready(b_rdy[1]), .m1_prdata(b_rdata[1]), .m1_pslverr(b_err[1]),
    .out_paddr(b_paddr), .out_psel(b_psel), .out_penable(b_pen), .out_pprot(b_pprot),
    .out_pwrite(b_pwrite), .out_pwdata(b_pwdata), .out_pstrb(b_pstrb),
    .out_pready(ds_ready), .out_prdata(ds_rdata_bus), .out_pslverr(ds_err_bus)
  );

  int          sel;
  logic [1:0]  o_ctl;
  logic [71:0] o_pl;
  logic [33:0] o_rsp[2];

  assign o_ctl    = (sel == 0) ? {a_psel, a_pen} : {b_psel, b_pen};
  assign o_pl     = (sel == 0) ? {a_paddr, a_pprot, a_pwrite, a_pwdata, a_pstrb}
                               : {b_paddr, b_pprot, b_pwrite, b_pwdata, b_pstrb};
  assign o_rsp[0] = (sel == 0) ? {a_rdy[0], a_rdata[0], a_err[0]} : {b_rdy[0], b_rdata[0], b_err[0]};
  assign o_rsp[1] = (sel == 0) ? {a_rdy[1], a_rdata[1], a_err[1]} : {b_rdy[1], b_rdata[1], b_err[1]};

  int checks = 0;
  int errors = 0;

  int          ds_wait = 1;
  bit          ds_hang = 1'b0;
  logic [31:0] ds_data = '0;
  logic        ds_e    = 1'b0;
  int          acc_cnt = 0;
  int          grants[$];

  // Advance one clock, then present the downstream completer's response for this cycle
  task automatic cycle();
    @(posedge clk);
    #1;
    if (o_ctl == 2'b11) begin
      acc_cnt++;
      ds_ready = !ds_hang && (acc_cnt >= ds_wait);
    end else begin
      acc_cnt  = 0;
      ds_ready = 1'b0;
    end
    ds_rdata_bus = ds_ready ? ds_data : $urandom;
    ds_err_bus   = ds_ready ? ds_e : 1'($urandom);
    #1;
  endtask

  function automatic logic [71:0] req_pl(input int i);
    return {rq_addr[i], rq_prot[i], rq_write[i], rq_wdata[i], rq_strb[i]};
  endfunction

  task automatic issue(input int i);
    rq_addr[i]  = $urandom;
    rq_prot[i]  = 3'($urandom);
    rq_write[i] = 1'($urandom);
    rq_wdata[i] = $urandom;
    rq_strb[i]  = 4'($urandom);
    rq_en[i]    = 1'($urandom);
    rq_sel[i]   = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rq_sel[0] = 1'b0;
    rq_sel[1] = 1'b0;
    ds_hang   = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Arbitration rule: lone requester wins; on contention alternate (rr) or m0
  function automatic int winner(input bit [1:0] ps, input int last_m, input bit rr);
    if (ps == 2'b11) return rr ? ((last_m == 0) ? 1 : 0) : 0;
    return ps[1] ? 1 : 0;
  endfunction

  // Random traffic from both requesters, checked cycle by cycle against a transfer-level model
  task automatic run_traffic(input int n0, input int n1, input int gap_max,
                             input int wait_max, input int budget);
    int          rem[2];
    int          gap[2];
    int          ph;
    int          acc;
    int          gnt_m;
    int          last_m;
    int          cyc;
    int          tmo;
    bit          done;
    bit          rr;
    bit [1:0]    ps;
    logic [1:0]  exp_ctl;
    logic [71:0] pl_prev[2];
    logic [71:0] exp_pl;
    logic [33:0] exp_rsp;
    rem[0] = n0; rem[1] = n1; gap[0] = 0; gap[1] = 0;
    ph = 0; acc = 0; gnt_m = 0; last_m = 1; cyc = 0; done = 1'b0; exp_pl = '0;
    rr  = (sel == 0);
    tmo = (sel == 0) ? 8 : 0;
    grants.delete();
    for (int i = 0; i < 2; i++) if (rem[i] > 0) begin issue(i); rem[i]--; end
    while ((rem[0] + rem[1] > 0 || rq_sel[0] || rq_sel[1] || ph != 0) && cyc < budget) begin
      ps = {rq_sel[1], rq_sel[0]};
      pl_prev[0] = req_pl(0);
      pl_prev[1] = req_pl(1);
      if (ph == 0 && ps != 2'b00) begin
        ds_wait = $urandom_range(1, wait_max);
        ds_data = $urandom;
        ds_e    = 1'($urandom);
      end
      cycle();
      cyc++;
      if (ph == 0) begin
        if (ps != 2'b00) begin
          gnt_m  = winner(ps, last_m, rr);
          exp_pl = pl_prev[gnt_m];
          ph     = 1;
        end
      end else if (ph == 1) begin
        ph  = 2;
        acc = 1;
      end else if (done) begin
        ph = 0;
      end else begin
        acc++;
      end
      exp_ctl = (ph == 0) ? 2'b00 : ((ph == 1) ? 2'b10 : 2'b11);
      checks++;
      if (o_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL traffic_ctl cyc=%0d psel/penable got=%b exp=%b", cyc, o_ctl, exp_ctl);
      end
      if (ph != 0) begin
        checks++;
        if (o_pl !== exp_pl) begin
          errors++;
          $display("FAIL traffic_payload cyc=%0d got=%h exp=%h", cyc, o_pl, exp_pl);
        end
      end
      done = (ph == 2) && (ds_ready || (tmo != 0 && acc == tmo));
      for (int i = 0; i < 2; i++) begin
        exp_rsp = '0;
        if (done && gnt_m == i)
          exp_rsp = ds_ready ? {1'b1, ds_rdata_bus, ds_err_bus} : {1'b1, 32'h0, 1'b1};
        checks++;
        if (o_rsp[i] !== exp_rsp) begin
          errors++;
          $display("FAIL traffic_rsp m%0d cyc=%0d got=%h exp=%h", i, cyc, o_rsp[i], exp_rsp);
        end
        if (o_rsp[i][33] === 1'b1) grants.push_back(i);
      end
      if (done) last_m = gnt_m;
      for (int i = 0; i < 2; i++) begin
        if (rq_sel[i] && done && gnt_m == i) begin
          rq_sel[i] = 1'b0;
          gap[i]    = $urandom_range(0, gap_max);
        end
        if (!rq_sel[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (rem[i] > 0) begin issue(i); rem[i]--; end
        end
      end
    end
    checks++;
    if (cyc >= budget) begin
      errors++;
      $display("FAIL traffic_budget cycles=%0d limit=%0d", cyc, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue(0);
    issue(1);
    ds_data = 32'hFFFF_FFFF;
    cycle();
    cycle();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_ctl, o_pl} !== 74'h0) begin
        errors++;
        $display("FAIL reset_out dut=%0d got=%h exp=0", s, {o_ctl, o_pl});
      end
      checks++;
      if ({o_rsp[0], o_rsp[1]} !== 68'h0) begin
        errors++;
        $display("FAIL reset_rsp dut=%0d got=%h exp=0", s, {o_rsp[0], o_rsp[1]});
      end
    end
    sel = 0;
    rq_sel[0] = 1'b0;
    rq_sel[1] = 1'b0;
    reset = 1'b0;
    cycle();
    cycle();
    checks++;
    if (o_ctl !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=00", o_ctl);
    end
  endtask

  task automatic test_single_read();
    int          n_psel, n_pen, n_rdy, n_rdy1, at;
    logic [33:0] rsp;
    logic [31:0] setup_addr;
    logic        setup_write;
    sel = 0;
    do_reset();
    ds_wait = 2; ds_data = 32'hDEAD_BEEF; ds_e = 1'b0;
    rq_addr[0] = 32'h1000_0004; rq_write[0] = 1'b0; rq_prot[0] = 3'b000;
    rq_wdata[0] = '0; rq_strb[0] = 4'h0; rq_sel[0] = 1'b1;
    n_psel = 0; n_pen = 0; n_rdy = 0; n_rdy1 = 0; at = -1; rsp = '0;
    setup_addr = '0; setup_write = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (c == 1) begin setup_addr = o_pl[71:40]; setup_write = o_pl[36]; end
      n_psel += int'(o_ctl[1]);
      n_pen  += int'(o_ctl[0]);
      if (o_rsp[1][33] === 1'b1) n_rdy1++;
      if (o_rsp[0][33] === 1'b1) begin n_rdy++; at = c; rsp = o_rsp[0]; rq_sel[0] = 1'b0; end
    end
    checks++;
    if ({n_psel, n_pen, n_rdy, n_rdy1} !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL single_counts psel=%0d pen=%0d rdy0=%0d rdy1=%0d exp 3 2 1 0", n_psel, n_pen, n_rdy, n_rdy1);
    end
    checks++;
    if (at != 3) begin
      errors++;
      $display("FAIL single_latency got=%0d exp=3", at);
    end
    checks++;
    if (rsp !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp got=%h exp=%h", rsp, {1'b1, 32'hDEAD_BEEF, 1'b0});
    end
    checks++;
    if ({setup_addr, setup_write} !== {32'h1000_0004, 1'b0}) begin
      errors++;
      $display("FAIL single_addr got=%h/%b exp=10000004/0", setup_addr, setup_write);
    end
  endtask

  task automatic test_write_strobe();
    logic [71:0] exp;
    int          n_psel, n_rdy;
    sel = 0;
    do_reset();
    ds_wait = 3; ds_data = $urandom; ds_e = 1'b0;
    rq_addr[1] = 32'h1000_0008; rq_prot[1] = 3'b010; rq_write[1] = 1'b1;
    rq_wdata[1] = 32'h1234_5678; rq_strb[1] = 4'b0011; rq_sel[1] = 1'b1;
    exp = {32'h1000_0008, 3'b010, 1'b1, 32'h1234_5678, 4'b0011};
    n_psel = 0; n_rdy = 0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (o_ctl[1] === 1'b1) begin
        n_psel++;
        checks++;
        if (o_pl !== exp) begin
          errors++;
          $display("FAIL write_payload cyc=%0d got=%h exp=%h", c, o_pl, exp);
        end
      end
      if (o_rsp[0][33] === 1'b1) n_rdy = n_rdy + 100;
      if (o_rsp[1][33] === 1'b1) begin n_rdy++; rq_sel[1] = 1'b0; end
    end
    checks++;
    if ({n_psel, n_rdy} !== {32'd4, 32'd1}) begin
      errors++;
      $display("FAIL write_counts psel=%0d rdy=%0d exp 4 1", n_psel, n_rdy);
    end
  endtask

  task automatic test_timeout();
    int          n_acc, at_acc;
    logic [33:0] rsp;
    logic [31:0] d;
    sel = 0;
    do_reset();
    ds_hang = 1'b1;
    issue(0);
    rq_write[0] = 1'b0;
    n_acc = 0; at_acc = -1; rsp = '0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (o_ctl == 2'b11) n_acc++;
      if (o_rsp[0][33] === 1'b1) begin at_acc = n_acc; rsp = o_rsp[0]; rq_sel[0] = 1'b0; break; end
    end
    checks++;
    if (at_acc != 8) begin
      errors++;
      $display("FAIL timeout_cycle got=%0d exp=8", at_acc);
    end
    checks++;
    if (rsp !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp got=%h exp=%h", rsp, {1'b1, 32'h0, 1'b1});
    end
    cycle();
    checks++;
    if (o_ctl !== 2'b00) begin
      errors++;
      $display("FAIL timeout_abandon got=%b exp=00", o_ctl);
    end
    ds_hang = 1'b0; ds_wait = 1; d = $urandom; ds_data = d; ds_e = 1'b0;
    issue(0);
    rsp = '0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (o_rsp[0][33] === 1'b1) begin rsp = o_rsp[0]; rq_sel[0] = 1'b0; break; end
    end
    checks++;
    if (rsp !== {1'b1, d, 1'b0}) begin
      errors++;
      $display("FAIL timeout_recover got=%h exp=%h", rsp, {1'b1, d, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a0;
    sel = 0;
    do_reset();
    run_traffic(1, 0, 0, 2, 50);
    ds_hang = 1'b1;
    issue(1);
    cycle();
    cycle();
    cycle();
    checks++;
    if (o_ctl !== 2'b11) begin
      errors++;
      $display("FAIL resetmid_access got=%b exp=11", o_ctl);
    end
    reset = 1'b1;
    issue(0);
    a0 = rq_addr[0];
    cycle();
    checks++;
    if ({o_ctl, o_pl, o_rsp[0], o_rsp[1]} !== 142'h0) begin
      errors++;
      $display("FAIL resetmid_clear ctl=%b rdy0=%b rdy1=%b exp all zero", o_ctl, o_rsp[0][33], o_rsp[1][33]);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if ({o_ctl, o_pl[71:40]} !== {2'b10, a0}) begin
      errors++;
      $display("FAIL resetmid_grant got=%b/%h exp=10/%h", o_ctl, o_pl[71:40], a0);
    end
    do_reset();
  endtask

  task automatic test_contention_rr();
    int exp_order[4] = '{0, 1, 0, 1};
    sel = 0;
    do_reset();
    run_traffic(2, 2, 0, 3, 200);
    checks++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grants[k] != exp_order[k]) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=m%0d exp=m%0d", k, grants[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_contention_fixed();
    int exp_order[6] = '{0, 0, 0, 1, 1, 1};
    sel = 1;
    do_reset();
    run_traffic(3, 3, 0, 4, 300);
    checks++;
    if (grants.size() != 6) begin
      errors++;
      $display("FAIL fixed_count got=%0d exp=6", grants.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grants[k] != exp_order[k]) begin
          errors++;
          $display("FAIL fixed_order idx=%0d got=m%0d exp=m%0d", k, grants[k], exp_order[k]);
        end
      end
    end
    sel = 0;
  endtask

  task automatic test_random();
    sel = 0;
    do_reset();
    run_traffic(10, 10, 3, 10, 4000);
    sel = 1;
    do_reset();
    run_traffic(8, 8, 2, 5, 3000);
    sel = 0;
  endtask

  initial begin
    reset = 1'b1;
    sel   = 0;
    for (int i = 0; i < 2; i++) begin
      rq_addr[i] = '0; rq_prot[i] = '0; rq_write[i] = 1'b0; rq_wdata[i] = '0;
      rq_strb[i] = '0; rq_sel[i] = 1'b0; rq_en[i] = 1'b0;
    end
    ds_ready = 1'b0; ds_rdata_bus = '0; ds_err_bus = 1'b0;
    test_reset();
    test_single_read();
    test_write_strobe();
    test_contention_rr();
    test_contention_fixed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
